// File: rtl/scr1_memif_pkg.sv
// Memory interface command and response encodings shared by the core-side ports.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_tb_imem_pkg.sv
// Types, widths and helpers for the testbench instruction-memory responder.
package scr1_tb_imem_pkg;

  localparam int unsigned SCR1_TB_IMEM_AW       = 32;
  localparam int unsigned SCR1_TB_IMEM_DW       = 32;
  localparam int unsigned SCR1_TB_IMEM_CNT_W    = 4;
  localparam int unsigned SCR1_TB_IMEM_ERRCNT_W = 16;

  typedef struct packed {
    logic [SCR1_TB_IMEM_AW-1:0]    addr;
    logic                          err;
    logic [SCR1_TB_IMEM_CNT_W-1:0] cnt;
  } type_scr1_tb_imem_req_s;

  function automatic logic [SCR1_TB_IMEM_CNT_W-1:0] scr1_tb_imem_cnt_dec(
    input logic [SCR1_TB_IMEM_CNT_W-1:0] c
  );
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // Window end is computed one bit wider so a window touching 4 GiB cannot wrap.
  function automatic logic scr1_tb_imem_addr_err(
    input logic                       cmd_wr,
    input logic [SCR1_TB_IMEM_AW-1:0] addr,
    input logic [SCR1_TB_IMEM_AW-1:0] base,
    input int unsigned                words
  );
    logic [SCR1_TB_IMEM_AW:0] lim;
    lim = {1'b0, base} + ({1'b0, SCR1_TB_IMEM_AW'(words)} << 2);
    return cmd_wr || (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
  endfunction

endpackage : scr1_tb_imem_pkg

// File: rtl/scr1_tb_imem_fifo.sv
// In-order request queue; every stored entry counts down toward its response slot.
module scr1_tb_imem_fifo
  import scr1_tb_imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  type_scr1_tb_imem_req_s push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output type_scr1_tb_imem_req_s head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic                   wr_en, rd_en;
  type_scr1_tb_imem_req_s mem_q [DEPTH];

  // The accept cycle is an entry's first cycle in the queue: an empty queue
  // exposes the incoming request as head, and it is stored already decremented.
  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    head   = empty ? push_data : mem_q[rptr_q[PW-1:0]];
    wr_en  = push && !(pop && empty);
    rd_en  = pop && !empty;
    wptr_d = wptr_q + {{PW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{PW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i].cnt <= scr1_tb_imem_cnt_dec(mem_q[i].cnt);
    end
    if (wr_en) begin
      mem_q[wptr_q[PW-1:0]].addr <= push_data.addr;
      mem_q[wptr_q[PW-1:0]].err  <= push_data.err;
      mem_q[wptr_q[PW-1:0]].cnt  <= scr1_tb_imem_cnt_dec(push_data.cnt);
    end
  end

endmodule : scr1_tb_imem_fifo

// File: rtl/scr1_tb_imem_responder.sv
// Fixed-latency instruction memory model answering core fetches in accept order.
module scr1_tb_imem_responder
  import scr1_memif_pkg::*;
  import scr1_tb_imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         imem_req,
  input  type_scr1_mem_cmd_e           imem_cmd,
  input  logic [31:0]                  imem_addr,
  output logic                         imem_req_ack,
  output logic [31:0]                  imem_rdata,
  output type_scr1_mem_resp_e          imem_resp,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
  input  logic [31:0]                  ld_data,
  output logic [31:0]                  resp_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0]            mem [MEM_WORDS];
  logic                   fifo_full, fifo_empty, push, pop;
  type_scr1_tb_imem_req_s push_entry, head;
  type_scr1_mem_resp_e    resp_q, resp_d;
  logic [31:0]            rdata_q, rdata_d, resp_cnt_q, resp_cnt_d;
  logic [15:0]            err_cnt_q, err_cnt_d;

  scr1_tb_imem_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    imem_req_ack    = !fifo_full;
    push            = imem_req && !fifo_full;
    push_entry.addr = imem_addr;
    push_entry.err  = scr1_tb_imem_addr_err(imem_cmd == SCR1_MEM_CMD_WR, imem_addr,
                                            BASE_ADDR, MEM_WORDS);
    push_entry.cnt  = SCR1_TB_IMEM_CNT_W'(LATENCY - 1);
    pop             = (!fifo_empty || push) && (head.cnt == '0);

    resp_d     = SCR1_MEM_RESP_NOTRDY;
    rdata_d    = '0;
    resp_cnt_d = resp_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (pop) begin
      if (head.err) begin
        resp_d = SCR1_MEM_RESP_RDY_ER;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        resp_d     = SCR1_MEM_RESP_RDY_OK;
        rdata_d    = mem[IDX_W'((head.addr - BASE_ADDR) >> 2)];
        resp_cnt_d = resp_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q     <= SCR1_MEM_RESP_NOTRDY;
      rdata_q    <= '0;
      resp_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      resp_cnt_q <= resp_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign resp_cnt   = resp_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule : scr1_tb_imem_responder

// File: tb/tb_scr1_tb_imem_responder.sv
// Bench for three responder configurations driven by one shared fetch stream.
module tb_scr1_tb_imem_responder;
  import scr1_memif_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req = 1'b0;
  logic               ld_en = 1'b0;
  type_scr1_mem_cmd_e cmd = SCR1_MEM_CMD_RD;
  logic [31:0]        addr = '0;
  logic [31:0]        ld_data = '0;
  logic [9:0]         ld_idx = '0;

  logic [2:0]        ack_w;
  logic [2:0][1:0]   resp_w;
  logic [2:0][31:0]  rdata_w, rcnt_w;
  logic [2:0][15:0]  ecnt_w;

  scr1_tb_imem_responder u0 (
    .clk(clk), .rst(rst), .imem_req(req), .imem_cmd(cmd), .imem_addr(addr),
    .imem_req_ack(ack_w[0]), .imem_rdata(rdata_w[0]), .imem_resp(resp_w[0]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .resp_cnt(rcnt_w[0]), .err_cnt(ecnt_w[0])
  );

  scr1_tb_imem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .imem_req(req), .imem_cmd(cmd), .imem_addr(addr),
    .imem_req_ack(ack_w[1]), .imem_rdata(rdata_w[1]), .imem_resp(resp_w[1]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .resp_cnt(rcnt_w[1]), .err_cnt(ecnt_w[1])
  );

  scr1_tb_imem_responder #(.LATENCY(8), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .imem_req(req), .imem_cmd(cmd), .imem_addr(addr),
    .imem_req_ack(ack_w[2]), .imem_rdata(rdata_w[2]), .imem_resp(resp_w[2]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .resp_cnt(rcnt_w[2]), .err_cnt(ecnt_w[2])
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit model_ok = 1'b0;

  // Model: a response calendar per instance, slot = accept cycle + latency.
  logic [31:0] mem_m [1024];
  logic        sv [3][64];
  logic        se [3][64];
  logic [31:0] sd [3][64];
  int          m_rcnt [3];
  int          m_ecnt [3];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 8;
  endfunction

  function automatic logic exp_err(input logic wr, input logic [31:0] a);
    longint unsigned ua;
    ua = a;
    return wr || (ua % 4 != 0) || (ua < 64'h200) || (ua >= 64'h200 + 4 * 1024);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s u%0d cyc=%0d got=%h want=%h", nm, k, cyc, got, exp);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int          occ;
      logic        eack;
      logic [31:0] off;
      int          s;
      if (model_ok) begin
        occ = 0;
        for (int d = 1; d <= 15; d++) occ += int'(sv[k][(cyc + d) % 64]);
        eack = (occ < 4);
        chk("ack", k, {31'd0, ack_w[k]}, {31'd0, eack});
        s = cyc % 64;
        if (sv[k][s]) begin
          if (se[k][s]) begin
            if (m_ecnt[k] < 65535) m_ecnt[k]++;
            chk("resp", k, {30'd0, resp_w[k]}, 32'd2);
            chk("rdata", k, rdata_w[k], 32'd0);
          end else begin
            m_rcnt[k]++;
            chk("resp", k, {30'd0, resp_w[k]}, 32'd1);
            chk("rdata", k, rdata_w[k], sd[k][s]);
          end
          sv[k][s] = 1'b0;
        end else begin
          chk("resp", k, {30'd0, resp_w[k]}, 32'd0);
          chk("rdata", k, rdata_w[k], 32'd0);
        end
        chk("resp_cnt", k, rcnt_w[k], m_rcnt[k]);
        chk("err_cnt", k, {16'd0, ecnt_w[k]}, m_ecnt[k]);
        if (!rst && req && eack) begin
          s = (cyc + lat_of(k)) % 64;
          off = addr - 32'h200;
          sv[k][s] = 1'b1;
          se[k][s] = exp_err(cmd == SCR1_MEM_CMD_WR, addr);
          sd[k][s] = se[k][s] ? 32'd0 : mem_m[off[11:2]];
        end
      end
      if (rst) begin
        for (int j = 0; j < 64; j++) sv[k][j] = 1'b0;
        m_rcnt[k] = 0;
        m_ecnt[k] = 0;
      end
    end
    if (rst) model_ok = 1'b1;
    if (ld_en) mem_m[ld_idx] = ld_data;
    cyc++;
  end

  task automatic step(input logic r, input logic [31:0] a, input logic wr);
    @(posedge clk);
    #1;
    req  = r;
    addr = a;
    cmd  = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [9:0]  li [5];
    logic [31:0] lv [5];
    int          acks;
    li = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd1023};
    lv = '{32'h00B51463, 32'h00000093, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D};

    // Preload while reset is held.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      ld_en = 1'b1; ld_idx = li[i]; ld_data = lv[i];
    end
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    rst   = 1'b0;
    idle(2);

    // Single fetch, latency 2.
    step(1'b1, 32'h200, 1'b0);
    idle(2);
    @(negedge clk);
    chk("A_resp", 0, {30'd0, resp_w[0]}, 32'd1);
    chk("A_rdata", 0, rdata_w[0], 32'h00B51463);
    chk("A_rcnt", 0, rcnt_w[0], 32'd1);
    idle(10);

    // Back-to-back fetches.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0);
    idle(1);
    @(negedge clk);
    chk("B_resp", 1, {30'd0, resp_w[1]}, 32'd1);
    chk("B_rdata", 1, rdata_w[1], 32'hDEADBEEF);
    idle(10);

    // Misaligned, below window, write.
    step(1'b1, 32'h202, 1'b0);
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h200, 1'b1);
    idle(12);
    @(negedge clk);
    chk("D_ecnt", 0, {16'd0, ecnt_w[0]}, 32'd3);
    chk("D_rcnt", 0, rcnt_w[0], 32'd5);
    chk("D_ecnt", 2, {16'd0, ecnt_w[2]}, 32'd3);

    // Last word of the window and first word past it.
    step(1'b1, 32'h11FC, 1'b0);
    step(1'b1, 32'h1200, 1'b0);
    idle(12);

    // Request held high against a 4-deep queue at latency 8.
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h200 + 32'(4 * (i % 4)), 1'b0);
      @(negedge clk);
      if (i < 8) acks += int'(ack_w[2]);
      if (i == 8) chk("C_ack_back", 2, {31'd0, ack_w[2]}, 32'd1);
    end
    chk("C_acks", 2, acks, 32'd4);
    idle(16);

    // Reset with three requests in flight.
    step(1'b1, 32'h200, 1'b0);
    step(1'b1, 32'h204, 1'b0);
    step(1'b1, 32'h208, 1'b0);
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("E_resp", 2, {30'd0, resp_w[2]}, 32'd0);
    chk("E_rdata", 2, rdata_w[2], 32'd0);
    chk("E_rcnt", 2, rcnt_w[2], 32'd0);
    chk("E_ecnt", 2, {16'd0, ecnt_w[2]}, 32'd0);
    chk("E_ack", 2, {31'd0, ack_w[2]}, 32'd1);
    chk("E_rcnt", 0, rcnt_w[0], 32'd0);
    idle(3);
    step(1'b1, 32'h204, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 32'd0, 1'b0);
      @(negedge clk);
      if (j == 2) begin
        chk("E_fresh_resp", 0, {30'd0, resp_w[0]}, 32'd1);
        chk("E_fresh_rdata", 0, rdata_w[0], 32'h00000093);
      end
      if (j == 8) begin
        chk("E_fresh_rdata", 2, rdata_w[2], 32'h00000093);
        chk("E_fresh_rcnt", 2, rcnt_w[2], 32'd1);
      end
    end
    idle(4);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_scr1_tb_imem_responder
